// File: rtl/frame_receiver_pkg.sv
// Shared constants for the dual-rail frame receiver.
// FRAME_RECEIVER_PARITY_EN adds a trailing odd-parity symbol.
package frame_rx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FRAME = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] SYM_SPACER = 2'b00;
  localparam logic [1:0] SYM_ZERO   = 2'b01;
  localparam logic [1:0] SYM_ONE    = 2'b10;
  localparam logic [1:0] SYM_CTRL   = 2'b11;

`ifdef FRAME_RECEIVER_PARITY_EN
  localparam int FRAME_BITS = 9;
`else
  localparam int FRAME_BITS = 8;
`endif

  localparam logic [3:0] FRAME_CNT = 4'(FRAME_BITS);
  localparam logic [3:0] CNT_MAX   = 4'hF;

  typedef struct packed {
    logic fs;
    logic fe;
    logic one;
    logic zero;
  } ack_t;

endpackage

// File: rtl/frame_receiver_if.sv
// Channel/consumer side signals of the frame receiver.
// master drives symbols and rd; slave is the receiver.
interface frame_receiver_if;
  logic       bit0;
  logic       bit1;
  logic       rd;
  logic       fs_ack;
  logic       fe_ack;
  logic       one_ack;
  logic       zero_ack;
  logic       xo_ack;
  logic       fd_ack;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;

  modport master (
    output bit0, bit1, rd,
    input  fs_ack, fe_ack, one_ack, zero_ack,
    input  xo_ack, fd_ack, data, data_valid, frame_err
  );

  modport slave (
    input  bit0, bit1, rd,
    output fs_ack, fe_ack, one_ack, zero_ack,
    output xo_ack, fd_ack, data, data_valid, frame_err
  );
endinterface

// File: rtl/frame_receiver_sym_sync.sv
// Two-flop synchronizer plus a two-sample stability filter
// for the asynchronous dual-rail symbol.
module sym_sync (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       bit0,
  input  logic       bit1,
  output logic [1:0] sym,
  output logic       sym_valid
);

  logic [1:0] s1_q;
  logic [1:0] s2_q;
  logic [1:0] s3_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_q <= 2'b00;
      s2_q <= 2'b00;
      s3_q <= 2'b00;
    end else begin
      s1_q <= {bit1, bit0};
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign sym       = s2_q;
  assign sym_valid = (s2_q == s3_q);

endmodule

// File: rtl/frame_receiver.sv
// Dual-rail frame receiver: start/data/end symbols with
// return-to-spacer acks. Optional FRAME_RECEIVER_PARITY_EN.
module frame_receiver
  import frame_rx_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  frame_receiver_if.slave  bus
);

  logic [1:0] sym;
  logic       sym_valid;

  sym_sync u_sync (
    .Clk       (Clk),
    .Reset     (Reset),
    .bit0      (bus.bit0),
    .bit1      (bus.bit1),
    .sym       (sym),
    .sym_valid (sym_valid)
  );

  logic [1:0]            state_q, state_d;
  logic [1:0]            ret_q, ret_d;
  ack_t                  ack_q, ack_d;
  logic                  xo_q, xo_d;
  logic                  err_q, err_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            data_q, data_d;
  logic                  par_ok;
  logic                  good;
  logic                  is_bit;

`ifdef FRAME_RECEIVER_PARITY_EN
  assign par_ok = ^sr_q;
`else
  assign par_ok = 1'b1;
`endif

  assign good   = (cnt_q == FRAME_CNT) && !ovf_q && par_ok;
  assign is_bit = (sym == SYM_ZERO) || (sym == SYM_ONE);

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    ack_d   = ack_q;
    xo_d    = 1'b0;
    err_d   = 1'b0;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (sym_valid && sym == SYM_CTRL) begin
          ack_d.fs = 1'b1;
          sr_d     = '0;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          ret_d    = ST_FRAME;
          state_d  = ST_ACK;
        end else if (sym_valid && is_bit) begin
          ack_d.one  = (sym == SYM_ONE);
          ack_d.zero = (sym == SYM_ZERO);
          err_d      = 1'b1;
          ret_d      = ST_IDLE;
          state_d    = ST_ACK;
        end
      end
      (state_q == ST_FRAME): begin
        if (sym_valid && is_bit) begin
          ack_d.one  = (sym == SYM_ONE);
          ack_d.zero = (sym == SYM_ZERO);
          // Surplus bits are acked but never reach the word
          if (cnt_q < FRAME_CNT)
            sr_d = {sr_q[FRAME_BITS-2:0], sym == SYM_ONE};
          else
            ovf_d = 1'b1;
          if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 4'd1;
          ret_d   = ST_FRAME;
          state_d = ST_ACK;
        end else if (sym_valid && sym == SYM_CTRL) begin
          ack_d.fe = 1'b1;
          state_d  = ST_ACK;
          if (good) begin
            ret_d  = ST_DONE;
            data_d = sr_q[FRAME_BITS-1 -: 8];
          end else begin
            ret_d = ST_IDLE;
            err_d = 1'b1;
          end
        end
      end
      (state_q == ST_ACK): begin
        if (sym_valid && sym == SYM_SPACER) begin
          ack_d   = '0;
          xo_d    = 1'b1;
          state_d = ret_q;
        end
      end
      (state_q == ST_DONE): begin
        if (bus.rd)
          state_d = ST_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      ret_q   <= ST_IDLE;
      ack_q   <= '0;
      xo_q    <= 1'b0;
      err_q   <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      ack_q   <= ack_d;
      xo_q    <= xo_d;
      err_q   <= err_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
    end
  end

  assign bus.fs_ack     = ack_q.fs;
  assign bus.fe_ack     = ack_q.fe;
  assign bus.one_ack    = ack_q.one;
  assign bus.zero_ack   = ack_q.zero;
  assign bus.xo_ack     = xo_q;
  assign bus.fd_ack     = (state_q == ST_DONE);
  assign bus.data_valid = (state_q == ST_DONE);
  assign bus.data       = data_q;
  assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_frame_receiver.sv
// Directed bench for frame_receiver: frames, errors,
// backpressure and reset in the middle of an ack.
module tb_frame_receiver;

`ifdef FRAME_RECEIVER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  frame_receiver_if bus ();

  frame_receiver dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int npass = 0;
  int ntotal = 0;

  int cfs = 0, cfe = 0, cone = 0, czero = 0;
  int cxo = 0, cerr = 0, viol = 0;
  logic pfs = 0, pfe = 0, pone = 0, pzero = 0;

  always @(negedge Clk) begin
    if (bus.fs_ack && !pfs) cfs++;
    if (bus.fe_ack && !pfe) cfe++;
    if (bus.one_ack && !pone) cone++;
    if (bus.zero_ack && !pzero) czero++;
    if (bus.xo_ack) cxo++;
    if (bus.frame_err) cerr++;
    if ($countones({bus.fs_ack, bus.fe_ack,
                    bus.one_ack, bus.zero_ack}) > 1)
      viol++;
    pfs   = bus.fs_ack;
    pfe   = bus.fe_ack;
    pone  = bus.one_ack;
    pzero = bus.zero_ack;
  end

  int bfs, bfe, bone, bzero, bxo, berr;

  task automatic snap();
    bfs = cfs; bfe = cfe; bone = cone;
    bzero = czero; bxo = cxo; berr = cerr;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic put(logic [1:0] s);
    @(negedge Clk);
    bus.bit1 = s[1];
    bus.bit0 = s[0];
    tick(6);
  endtask

  task automatic send_bits(logic [15:0] v, int n);
    for (int i = n - 1; i >= 0; i--) begin
      put(v[i] ? 2'b10 : 2'b01);
      put(2'b00);
    end
  endtask

  task automatic send_word(logic [7:0] b);
`ifdef FRAME_RECEIVER_PARITY_EN
    send_bits({7'd0, b, ~^b}, 9);
`else
    send_bits({8'd0, b}, 8);
`endif
  endtask

  task automatic frame_word(logic [7:0] b);
    put(2'b11);
    put(2'b00);
    send_word(b);
    put(2'b11);
    put(2'b00);
  endtask

  task automatic frame_raw(logic [15:0] v, int n);
    put(2'b11);
    put(2'b00);
    send_bits(v, n);
    put(2'b11);
    put(2'b00);
  endtask

  task automatic pop();
    @(negedge Clk);
    bus.rd = 1'b1;
    tick(1);
    @(negedge Clk);
    bus.rd = 1'b0;
  endtask

  initial begin
    bus.bit0 = 1'b0;
    bus.bit1 = 1'b0;
    bus.rd   = 1'b0;
    Reset    = 1'b1;
    tick(3);
    chk("rst_flags", {24'd0, bus.fs_ack, bus.fe_ack,
        bus.one_ack, bus.zero_ack, bus.xo_ack, bus.fd_ack,
        bus.data_valid, bus.frame_err}, 32'd0);
    chk("rst_data", {24'd0, bus.data}, 32'h00);
    @(negedge Clk);
    Reset = 1'b0;
    tick(2);

    // Good frame A5, first symbol timed edge by edge
    snap();
    @(negedge Clk);
    bus.bit1 = 1'b1;
    bus.bit0 = 1'b1;
    tick(3);
    chk("lat_edge3", {31'd0, bus.fs_ack}, 32'd0);
    tick(1);
    chk("lat_edge4", {31'd0, bus.fs_ack}, 32'd1);
    tick(2);
    put(2'b00);
    send_word(8'hA5);
    put(2'b11);
    put(2'b00);
    chk("good_fs", cfs - bfs, 1);
    chk("good_one", cone - bone, 4 + PAR);
    chk("good_zero", czero - bzero, 4);
    chk("good_fe", cfe - bfe, 1);
    chk("good_xo", cxo - bxo, 10 + PAR);
    chk("good_err", cerr - berr, 0);
    chk("good_fd", {31'd0, bus.fd_ack}, 1);
    chk("good_dv", {31'd0, bus.data_valid}, 1);
    chk("good_data", {24'd0, bus.data}, 32'hA5);
    @(negedge Clk);
    bus.rd = 1'b1;
    tick(1);
    chk("rd_clear", {31'd0, bus.fd_ack}, 0);
    @(negedge Clk);
    bus.rd = 1'b0;

    // Short frame: 7 bits
    snap();
    frame_raw(16'h0055, 7);
    chk("short_err", cerr - berr, 1);
    chk("short_fd", {31'd0, bus.fd_ack}, 0);

    // Long frame: 10 bits
    snap();
    frame_raw(16'h02D3, 10);
    chk("long_acks", (cone - bone) + (czero - bzero), 10);
    chk("long_err", cerr - berr, 1);
    chk("long_fd", {31'd0, bus.fd_ack}, 0);

    // Stray data bit while idle
    snap();
    put(2'b01);
    chk("stray_zack", {31'd0, bus.zero_ack}, 1);
    put(2'b00);
    chk("stray_err", cerr - berr, 1);
    chk("stray_xo", cxo - bxo, 1);
    chk("stray_fd", {31'd0, bus.fd_ack}, 0);

    // Backpressure while holding 3C
    frame_word(8'h3C);
    chk("bp_data", {24'd0, bus.data}, 32'h3C);
    snap();
    @(negedge Clk);
    bus.bit1 = 1'b1;
    bus.bit0 = 1'b1;
    tick(20);
    chk("bp_noack", cfs - bfs, 0);
    chk("bp_hold", {31'd0, bus.fd_ack}, 1);
    chk("bp_stable", {24'd0, bus.data}, 32'h3C);
    @(negedge Clk);
    bus.rd = 1'b1;
    tick(1);
    chk("bp_idle", {30'd0, bus.fd_ack, bus.fs_ack}, 0);
    @(negedge Clk);
    bus.rd = 1'b0;
    tick(1);
    chk("bp_fs", {31'd0, bus.fs_ack}, 1);
    put(2'b00);

    // Reset while one_ack is held
    @(negedge Clk);
    bus.bit1 = 1'b1;
    bus.bit0 = 1'b0;
    tick(5);
    chk("mid_one", {31'd0, bus.one_ack}, 1);
    @(negedge Clk);
    Reset    = 1'b1;
    bus.bit1 = 1'b0;
    bus.bit0 = 1'b0;
    tick(1);
    chk("mid_flags", {24'd0, bus.fs_ack, bus.fe_ack,
        bus.one_ack, bus.zero_ack, bus.xo_ack, bus.fd_ack,
        bus.data_valid, bus.frame_err}, 32'd0);
    chk("mid_data", {24'd0, bus.data}, 32'h00);
    @(negedge Clk);
    Reset = 1'b0;
    tick(2);
    snap();
    frame_word(8'h5A);
    chk("post_fd", {31'd0, bus.fd_ack}, 1);
    chk("post_data", {24'd0, bus.data}, 32'h5A);
    chk("post_err", cerr - berr, 0);
    pop();

`ifdef FRAME_RECEIVER_PARITY_EN
    snap();
    frame_raw(16'h014A, 9);
    chk("par_bad_err", cerr - berr, 1);
    chk("par_bad_fd", {31'd0, bus.fd_ack}, 0);
    frame_raw(16'h014B, 9);
    chk("par_ok_fd", {31'd0, bus.fd_ack}, 1);
    chk("par_ok_data", {24'd0, bus.data}, 32'hA5);
    pop();
`endif

    chk("ack_onehot", viol, 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/frame_receiver.md
FRAME_RECEIVER -- requirements
Module: frame_receiver

Interface
REQ-001 SHALL have port Clk, input, 1, system clock; all logic on rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports bit0, bit1, input, 1 each, dual-rail symbol from Channel, asynchronous to Clk.
- Encoding {bit1,bit0}: 00 spacer, 01 zero, 10 one, 11 control.
REQ-004 SHALL have port rd, input, 1, consumer pop of the held word.
REQ-005 SHALL have ports fs_ack, fe_ack, one_ack, zero_ack, input-side handshakes, output, 1 each.
- Meanings: frame-start, frame-end, one and zero acknowledges to Channel.
REQ-006 SHALL have port xo_ack, output, 1, one-cycle pulse on each completed return-to-spacer.
REQ-007 SHALL have port fd_ack, output, 1, frame-done; high while a good word is held.
REQ-008 SHALL have port data, output, 8, received word, MSB first on the wire.
REQ-009 SHALL have port data_valid, output, 1, equal to fd_ack.
REQ-010 SHALL have port frame_err, output, 1, one-cycle error pulse.

Function
REQ-011 SHALL pass bit0/bit1 through a 2-flop synchronizer, then a stability filter.
- Filter: a symbol is accepted only when two consecutive synced samples are equal.
- Result: an ack is asserted on the 4th rising edge after a clean input change.
REQ-012 SHALL implement states IDLE, FRAME, ACK, DONE.
REQ-013 IDLE: accepted 11 -> assert fs_ack, clear shift register and count, go to ACK with return state FRAME.
REQ-014 IDLE: accepted 01/10 -> assert zero_ack/one_ack, pulse frame_err, discard the bit, go to ACK with return state IDLE.
REQ-015 FRAME: accepted 01/10 -> shift 0/1 into the LSB, increment count (4-bit, saturating at 15), assert the matching ack, go to ACK.
REQ-016 FRAME: bits beyond the expected count SHALL still be acked; they are not stored, and the frame is marked overflowed.
REQ-017 FRAME: accepted 11 -> assert fe_ack, go to ACK. The return state depends on the frame:
- Count equals expected and no overflow: return state DONE, latch data.
- Otherwise: return state IDLE, pulse frame_err.
REQ-018 ACK: the asserted ack SHALL hold until an accepted 00.
- Then: deassert the ack, pulse xo_ack for one cycle, enter the return state, all on the same edge.
REQ-019 At most one of fs_ack, fe_ack, one_ack, zero_ack SHALL be high in any cycle.
REQ-020 DONE: fd_ack=data_valid=1 and data is stable; input symbols are ignored and no ack is given (backpressure).
REQ-021 DONE with rd=1 SHALL clear fd_ack and go to IDLE on that edge. rd outside DONE SHALL be ignored.
REQ-022 A 00 while in IDLE or FRAME SHALL produce no ack and no xo_ack.

Reset
REQ-023 Reset=1 at a rising edge SHALL force the following, regardless of state (including mid-frame or in ACK):
- State IDLE.
- All acks, xo_ack, fd_ack, data_valid and frame_err at 0.
- data=8'h00 and count=0.
- Synchronizer flops at 00.
REQ-024 After Reset release, a symbol held on the inputs SHALL be treated as a fresh change, accepted per REQ-011.

Configuration
REQ-025 With FRAME_RECEIVER_PARITY_EN defined, a frame SHALL carry 9 data symbols: 8 data bits then one odd-parity bit.
- Parity mismatch at frame end: pulse frame_err, return IDLE, no DONE.
REQ-026 Without FRAME_RECEIVER_PARITY_EN, a frame SHALL carry exactly 8 data symbols and no parity check.

Structure
REQ-027 Package frame_rx_pkg SHALL hold the following; no other constants shall be local:
- The state encoding.
- The symbol codes SYM_SPACER/SYM_ZERO/SYM_ONE/SYM_CTRL.
- FRAME_BITS (8, or 9 with parity).
REQ-028 Sub-module sym_sync SHALL contain the synchronizer and stability filter, outputting sym[1:0] and sym_valid.

Verification
REQ-029 Good frame: 11, 00, then bits 1,0,1,0,0,1,0,1 each followed by 00, then 11, 00.
- Required: one fs_ack, 4 one_ack, 4 zero_ack, one fe_ack, 10 xo_ack pulses.
- Required: fd_ack=1 with data=8'hA5; rd=1 then clears fd_ack next edge.
REQ-030 Short frame: start, 7 bits, end -> frame_err pulse once, fd_ack stays 0, state IDLE.
REQ-031 Long frame: start, 10 bits, end -> all 10 bits acked, frame_err pulse, no DONE.
REQ-032 Backpressure: 11 applied while DONE holding 8'h3C -> no ack for 20 cycles; rd -> fs_ack asserts after the IDLE entry.
REQ-033 Reset mid-ACK: Reset=1 while one_ack is high -> next edge one_ack=0, all outputs at reset values; good frame afterwards completes normally.
REQ-034 Parity (FRAME_RECEIVER_PARITY_EN): 8'hA5 then parity bit 0 -> frame_err; parity bit 1 -> fd_ack with data=8'hA5.
